// File: rtl/i2c_frame_timer.sv
// I2C slave bit/byte/ACK phase timer: counts SCL edges inside a frame and marks
// word completion, the ACK slot phases and a programmable per-frame word limit.
module i2c_frame_timer #(
    parameter int DATA_BITS = 8,
    parameter int MAX_BYTES = 16,
    parameter int BC_W      = $clog2(MAX_BYTES + 1),
    localparam int BIT_W    = $clog2(DATA_BITS + 1)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             rising_edge_found,
    input  logic             falling_edge_found,
    input  logic             start_found,
    input  logic             stop_found,
    input  logic [BC_W-1:0]  byte_limit,
    output logic             byte_received,
    output logic             ack_prep,
    output logic             check_ack,
    output logic             ack_done,
    output logic             frame_active,
    output logic             limit_reached,
    output logic [BC_W-1:0]  byte_count,
    output logic [BIT_W-1:0] bit_count
);

    // state    | meaning
    // IDLE     | no frame, edges ignored
    // BITS     | sampling data bits on SCL rises
    // BYTE_RX  | word complete, byte_received pulse
    // WAIT_F   | waiting for SCL fall ahead of the ACK slot
    // ACK_PREP | SCL low, controller drives ACK on SDA
    // CHECK    | ACK-slot rise, check_ack pulse
    // WAIT_AF  | waiting for SCL fall closing the ACK slot
    // ACK_END  | ack_done pulse, decide next word or limit
    // LIMIT    | word limit hit, edges ignored until STOP/START
    typedef enum logic [3:0] {
        IDLE, BITS, BYTE_RX, WAIT_F, ACK_PREP, CHECK, WAIT_AF, ACK_END, LIMIT
    } state_t;

    localparam logic [BIT_W-1:0] BITS_FULL = BIT_W'(DATA_BITS);
    localparam logic [BC_W-1:0]  BYTES_MAX = BC_W'(MAX_BYTES);

    state_t           state_q, state_d;
    logic [BIT_W-1:0] bit_count_q, bit_count_d;
    logic [BC_W-1:0]  byte_count_q, byte_count_d;
    logic             byte_received_q, byte_received_d;
    logic             ack_prep_q, ack_prep_d;
    logic             check_ack_q, check_ack_d;
    logic             ack_done_q, ack_done_d;
    logic             frame_active_q, frame_active_d;
    logic             limit_reached_q, limit_reached_d;
    logic             rise, fall;

    // A fall coinciding with a rise is illegal upstream; the rise takes precedence.
    assign rise = rising_edge_found;
    assign fall = falling_edge_found & ~rising_edge_found;

    always_comb begin
        state_d      = state_q;
        bit_count_d  = bit_count_q;
        byte_count_d = byte_count_q;
        if (stop_found) begin
            state_d      = IDLE;
            bit_count_d  = '0;
            byte_count_d = '0;
        end else if (start_found) begin
            state_d      = BITS;
            bit_count_d  = '0;
            byte_count_d = '0;
        end else begin
            case (state_q)
                IDLE: state_d = IDLE;
                BITS: begin
                    if (bit_count_q == BITS_FULL) begin
                        state_d = BYTE_RX;
                        if (byte_count_q != BYTES_MAX) begin
                            byte_count_d = byte_count_q + BC_W'(1);
                        end
                    end else if (rise) begin
                        bit_count_d = bit_count_q + BIT_W'(1);
                    end
                end
                // Pulse states also take an edge directly so a 2-clk SCL phase is never lost.
                BYTE_RX:  state_d = fall ? ACK_PREP : WAIT_F;
                WAIT_F:   if (fall) state_d = ACK_PREP;
                ACK_PREP: if (rise) state_d = CHECK;
                CHECK:    state_d = fall ? ACK_END : WAIT_AF;
                WAIT_AF:  if (fall) state_d = ACK_END;
                ACK_END: begin
                    bit_count_d = '0;
                    if ((byte_limit != '0) && (byte_count_q >= byte_limit)) begin
                        state_d = LIMIT;
                    end else begin
                        state_d = BITS;
                    end
                end
                LIMIT:   state_d = LIMIT;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        byte_received_d = (state_d == BYTE_RX);
        ack_prep_d      = (state_d == ACK_PREP);
        check_ack_d     = (state_d == CHECK);
        ack_done_d      = (state_d == ACK_END);
        frame_active_d  = (state_d != IDLE);
        limit_reached_d = (state_d == LIMIT);
    end

    always_ff @(posedge clk) begin
        if (n_rst) begin
            state_q         <= IDLE;
            bit_count_q     <= '0;
            byte_count_q    <= '0;
            byte_received_q <= 1'b0;
            ack_prep_q      <= 1'b0;
            check_ack_q     <= 1'b0;
            ack_done_q      <= 1'b0;
            frame_active_q  <= 1'b0;
            limit_reached_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            bit_count_q     <= bit_count_d;
            byte_count_q    <= byte_count_d;
            byte_received_q <= byte_received_d;
            ack_prep_q      <= ack_prep_d;
            check_ack_q     <= check_ack_d;
            ack_done_q      <= ack_done_d;
            frame_active_q  <= frame_active_d;
            limit_reached_q <= limit_reached_d;
        end
    end

    assign byte_received = byte_received_q;
    assign ack_prep      = ack_prep_q;
    assign check_ack     = check_ack_q;
    assign ack_done      = ack_done_q;
    assign frame_active  = frame_active_q;
    assign limit_reached = limit_reached_q;
    assign byte_count    = byte_count_q;
    assign bit_count     = bit_count_q;

endmodule

// File: tb/tb_i2c_frame_timer.sv
// Directed bench for i2c_frame_timer: an 8-bit/16-word instance and a
// 12-bit/2-word instance share one SCL/START/STOP stimulus stream.
module tb_i2c_frame_timer;

    logic       clk;
    logic       n_rst;
    logic       rise, fall, start, stop;
    logic [4:0] byte_limit8;
    logic [1:0] byte_limit12;

    logic       br8, ap8, ca8, ad8, fa8, lr8;
    logic [4:0] bc8;
    logic [3:0] bit8;
    logic       br12, ap12, ca12, ad12, fa12, lr12;
    logic [1:0] bc12;
    logic [3:0] bit12;

    int n_checks = 0;
    int n_errors = 0;
    int br8_n = 0, ca8_n = 0, ad8_n = 0, br12_n = 0;
    int overlap_errs = 0;
    int fa_drop = 0;
    logic watch_fa = 1'b0;
    int s_br8, s_ca8, s_ad8, s_br12;

    i2c_frame_timer #(.DATA_BITS(8), .MAX_BYTES(16)) dut8 (
        .clk(clk), .n_rst(n_rst),
        .rising_edge_found(rise), .falling_edge_found(fall),
        .start_found(start), .stop_found(stop), .byte_limit(byte_limit8),
        .byte_received(br8), .ack_prep(ap8), .check_ack(ca8), .ack_done(ad8),
        .frame_active(fa8), .limit_reached(lr8),
        .byte_count(bc8), .bit_count(bit8)
    );

    i2c_frame_timer #(.DATA_BITS(12), .MAX_BYTES(2)) dut12 (
        .clk(clk), .n_rst(n_rst),
        .rising_edge_found(rise), .falling_edge_found(fall),
        .start_found(start), .stop_found(stop), .byte_limit(byte_limit12),
        .byte_received(br12), .ack_prep(ap12), .check_ack(ca12), .ack_done(ad12),
        .frame_active(fa12), .limit_reached(lr12),
        .byte_count(bc12), .bit_count(bit12)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        br8_n  = br8_n + int'(br8);
        ca8_n  = ca8_n + int'(ca8);
        ad8_n  = ad8_n + int'(ad8);
        br12_n = br12_n + int'(br12);
        if ((int'(br8) + int'(ap8) + int'(ca8) + int'(ad8)) > 1) overlap_errs = overlap_errs + 1;
        if ((int'(br12) + int'(ap12) + int'(ca12) + int'(ad12)) > 1) overlap_errs = overlap_errs + 1;
        if (watch_fa && !fa8) fa_drop = fa_drop + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present inputs for one clock, then sample #1 after the edge.
    task automatic drive(input logic r, input logic f, input logic s, input logic p);
        rise = r; fall = f; start = s; stop = p;
        @(posedge clk);
        #1;
        rise = 1'b0; fall = 1'b0; start = 1'b0; stop = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic scl_pulse();
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        idle(2);
    endtask

    task automatic snap();
        s_br8 = br8_n; s_ca8 = ca8_n; s_ad8 = ad8_n; s_br12 = br12_n;
    endtask

    initial begin
        n_rst = 1'b1;
        rise = 1'b0; fall = 1'b0; start = 1'b0; stop = 1'b0;
        byte_limit8 = '0;
        byte_limit12 = '0;
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b0;

        // reset state
        chk("rst_fa8", fa8, 0);
        chk("rst_bc8", bc8, 0);
        chk("rst_bit8", bit8, 0);
        chk("rst_outs8", {br8, ap8, ca8, ad8, lr8}, 0);
        chk("rst_fa12", fa12, 0);

        // edges without START are ignored
        snap();
        repeat (3) scl_pulse();
        chk("idle_fa8", fa8, 0);
        chk("idle_bit8", bit8, 0);
        chk("idle_br8", br8_n - s_br8, 0);

        // basic frame, 18 SCL pulses with detailed timing on the first word
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        chk("start_fa8", fa8, 1);
        snap();
        repeat (7) scl_pulse();
        chk("bits7", bit8, 7);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        chk("bit8_full", bit8, 8);
        chk("br_not_yet", br8, 0);
        idle(1);
        chk("br_pulse", br8, 1);
        chk("bc_upd", bc8, 1);
        idle(1);
        chk("br_one_cyc", br8, 0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        chk("ack_prep", ap8, 1);
        idle(2);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        chk("ack_prep_off", ap8, 0);
        chk("check_ack", ca8, 1);
        idle(2);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        chk("ack_done", ad8, 1);
        idle(2);
        chk("ack_done_off", ad8, 0);
        chk("bit_clr", bit8, 0);
        repeat (9) scl_pulse();
        chk("frame_bc8", bc8, 2);
        chk("frame_br8_n", br8_n - s_br8, 2);
        chk("frame_ca8_n", ca8_n - s_ca8, 2);
        chk("frame_ad8_n", ad8_n - s_ad8, 2);
        chk("frame_bc12", bc12, 1);
        chk("frame_bit12", bit12, 5);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        chk("stop_bc8", bc8, 0);
        chk("stop_fa8", fa8, 0);
        chk("stop_bit12", bit12, 0);

        // 12-bit word width
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (11) scl_pulse();
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        chk("w12_bits", bit12, 12);
        idle(1);
        chk("w12_br", br12, 1);
        chk("w12_bc", bc12, 1);
        idle(1);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        idle(2);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        chk("w12_check_ack", ca12, 1);
        chk("w12_ack_prep_off", ap12, 0);
        idle(2);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        idle(2);
        chk("w12_bc_end", bc12, 1);
        drive(1'b0, 1'b0, 1'b0, 1'b1);

        // byte_count saturation on the 2-word instance
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        snap();
        repeat (39) scl_pulse();
        chk("sat_bc12", bc12, 2);
        chk("sat_br12_n", br12_n - s_br12, 3);
        chk("sat_bc8", bc8, 4);
        chk("sat_bit8", bit8, 3);
        drive(1'b0, 1'b0, 1'b0, 1'b1);

        // word limit of 3
        byte_limit8 = 5'd3;
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        snap();
        repeat (18) scl_pulse();
        chk("lim_not_yet", lr8, 0);
        repeat (9) scl_pulse();
        chk("lim_hit", lr8, 1);
        chk("lim_bc", bc8, 3);
        repeat (9) scl_pulse();
        chk("lim_hold_bc", bc8, 3);
        chk("lim_br_n", br8_n - s_br8, 3);
        chk("lim_ad_n", ad8_n - s_ad8, 3);
        chk("lim_fa", fa8, 1);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        chk("lim_stop", lr8, 0);
        byte_limit8 = '0;

        // repeated START
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (13) scl_pulse();
        chk("rs_pre_bc", bc8, 1);
        chk("rs_pre_bit", bit8, 4);
        watch_fa = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        chk("rs_bit", bit8, 0);
        chk("rs_bc", bc8, 0);
        repeat (9) scl_pulse();
        chk("rs_bc_after", bc8, 1);
        watch_fa = 1'b0;
        chk("rs_fa_drop", fa_drop, 0);

        // STOP mid-word
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (5) scl_pulse();
        snap();
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        chk("smw_fa", fa8, 0);
        chk("smw_bit", bit8, 0);
        repeat (5) scl_pulse();
        chk("smw_br_n", br8_n - s_br8, 0);

        // STOP wins over simultaneous START
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (3) scl_pulse();
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        chk("stop_wins_fa", fa8, 0);
        chk("stop_wins_bit", bit8, 0);

        // reset during ACK_PREP
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (8) scl_pulse();
        chk("rmf_ack_prep", ap8, 1);
        n_rst = 1'b1;
        @(posedge clk);
        #1;
        n_rst = 1'b0;
        chk("rmf_ack_prep_off", ap8, 0);
        chk("rmf_bc", bc8, 0);
        chk("rmf_bit", bit8, 0);
        chk("rmf_fa", fa8, 0);

        idle(2);
        chk("no_overlap", overlap_errs, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
